// File: rtl/m68k_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : m68k_bus_ctrl_if
// Brief    : 68000 CPU-side bus signals and chip-select/DTACK/BERR pads.
// Revision : 1.0 - initial release
// ============================================================================
interface m68k_bus_ctrl_if #(
    parameter int NREGIONS = 4
);
    logic                as_n;
    logic                uds_n;
    logic                lds_n;
    logic                rw;
    logic                boot;
    logic [10:0]         addr;
    logic [NREGIONS-1:0] ext_ack;
    logic [NREGIONS-1:0] cs_n;
    logic                dtack_n;
    logic                dtack_oe;
    logic                berr_n;
    logic                berr_oe;
    logic                overlay;

    modport master (
        output as_n, uds_n, lds_n, rw, boot, addr, ext_ack,
        input  cs_n, dtack_n, dtack_oe, berr_n, berr_oe, overlay
    );

    modport slave (
        input  as_n, uds_n, lds_n, rw, boot, addr, ext_ack,
        output cs_n, dtack_n, dtack_oe, berr_n, berr_oe, overlay
    );
endinterface
`default_nettype wire

// File: rtl/m68k_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : m68k_bus_ctrl
// Brief    : 68000 address decoder with per-region wait states, boot overlay
//            and actively-negated DTACK/BERR. Define M68K_BUS_WATCHDOG_EN to
//            turn a stalled WAIT into a bus error after TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module m68k_bus_ctrl #(
    parameter int                       NREGIONS    = 4,
    parameter logic [NREGIONS*11-1:0]   REGION_BASE = {11'h180, 11'h100, 11'h080, 11'h000},
    parameter logic [NREGIONS*11-1:0]   REGION_MASK = {11'h780, 11'h7F8, 11'h7FE, 11'h780},
    parameter logic [NREGIONS*4-1:0]    REGION_WAIT = {4'hF, 4'd2, 4'd4, 4'd0},
    parameter int                       BOOT_REGION = 1,
    parameter int                       OVL_PAGES   = 2,
    parameter int                       TIMEOUT     = 255
) (
    input  wire logic       clk16,
    input  wire logic       reset_n,
    m68k_bus_ctrl_if.slave  bus
);

    localparam int         IDXW     = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;
    localparam logic [3:0] WAIT_EXT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ACK  = 3'd2,
        S_BERR = 3'd3,
        S_NEG  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [IDXW-1:0] sel_q, sel_d;
    logic            ext_q, ext_d;
    logic            neg_berr_q, neg_berr_d;
    logic            overlay_q, overlay_d;

    logic [NREGIONS-1:0] hit;
    logic [NREGIONS-1:0] cs_dec_n;
    logic                in_ovl;
    logic                ovl_route;
    logic                mapped;
    logic [IDXW-1:0]     sel;
    logic [3:0]          sel_wait;
    logic                ack_in;
    logic                strobe;

`ifdef M68K_BUS_WATCHDOG_EN
    logic [7:0] wdog_q, wdog_d;
    logic       wdog_expired;
    assign wdog_expired = ({1'b0, wdog_q} + 9'd1) >= 9'(TIMEOUT);
`else
    logic unused_timeout;
    assign unused_timeout = ^9'(TIMEOUT);
`endif

    generate
        for (genvar gi = 0; gi < NREGIONS; gi++) begin : g_hit
            assign hit[gi] = (bus.addr & REGION_MASK[gi*11 +: 11]) == REGION_BASE[gi*11 +: 11];
        end
    endgenerate

    // Overlay decode uses the pre-edge overlay flag, so the clearing write lands in RAM.
    assign in_ovl    = {21'd0, bus.addr} < 32'(OVL_PAGES);
    assign ovl_route = overlay_q & in_ovl & (bus.rw | bus.boot);
    assign strobe    = ~bus.as_n & ~(bus.uds_n & bus.lds_n);

    always_comb begin
        mapped = 1'b0;
        sel    = '0;
        for (int i = NREGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                mapped = 1'b1;
                sel    = IDXW'(i);
            end
        end
        if (ovl_route) begin
            mapped = 1'b1;
            sel    = IDXW'(BOOT_REGION);
        end
    end

    always_comb begin
        sel_wait = 4'd0;
        ack_in   = 1'b0;
        cs_dec_n = '1;
        for (int i = 0; i < NREGIONS; i++) begin
            if (sel == IDXW'(i)) begin
                sel_wait = REGION_WAIT[i*4 +: 4];
                if (!bus.as_n && mapped) begin
                    cs_dec_n[i] = 1'b0;
                end
            end
            if (sel_q == IDXW'(i)) begin
                ack_in = bus.ext_ack[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        sel_d      = sel_q;
        ext_d      = ext_q;
        neg_berr_d = neg_berr_q;
        overlay_d  = overlay_q;
`ifdef M68K_BUS_WATCHDOG_EN
        wdog_d     = wdog_q;
`endif

        if (!bus.as_n && !bus.rw && !bus.boot && in_ovl) begin
            overlay_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
`ifdef M68K_BUS_WATCHDOG_EN
                wdog_d = 8'd0;
`endif
                if (strobe && !bus.boot) begin
                    if (mapped) begin
                        sel_d   = sel;
                        ext_d   = (sel_wait == WAIT_EXT);
                        wcnt_d  = sel_wait;
                        state_d = (sel_wait == 4'd0) ? S_ACK : S_WAIT;
                    end else begin
                        state_d = S_BERR;
                    end
                end
            end
            S_WAIT: begin
`ifdef M68K_BUS_WATCHDOG_EN
                wdog_d = wdog_q + 8'd1;
`endif
                if (bus.as_n) begin
                    state_d = S_IDLE;
                    wcnt_d  = 4'd0;
                end else if (ext_q) begin
                    if (ack_in) begin
                        state_d = S_ACK;
                    end
                end else if (wcnt_q <= 4'd1) begin
                    wcnt_d  = 4'd0;
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
`ifdef M68K_BUS_WATCHDOG_EN
                if (!bus.as_n && state_d == S_WAIT && wdog_expired) begin
                    state_d = S_BERR;
                end
`endif
            end
            S_ACK: begin
                if (bus.as_n) begin
                    state_d    = S_NEG;
                    neg_berr_d = 1'b0;
                end
            end
            S_BERR: begin
                if (bus.as_n) begin
                    state_d    = S_NEG;
                    neg_berr_d = 1'b1;
                end
            end
            S_NEG: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 4'd0;
            sel_q      <= '0;
            ext_q      <= 1'b0;
            neg_berr_q <= 1'b0;
            overlay_q  <= 1'b1;
`ifdef M68K_BUS_WATCHDOG_EN
            wdog_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            sel_q      <= sel_d;
            ext_q      <= ext_d;
            neg_berr_q <= neg_berr_d;
            overlay_q  <= overlay_d;
`ifdef M68K_BUS_WATCHDOG_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    // NEG drives the released strobe high for one cycle before the pad floats.
    assign bus.cs_n     = cs_dec_n;
    assign bus.dtack_n  = (state_q != S_ACK);
    assign bus.dtack_oe = (state_q == S_ACK) | ((state_q == S_NEG) & ~neg_berr_q);
    assign bus.berr_n   = (state_q != S_BERR);
    assign bus.berr_oe  = (state_q == S_BERR) | ((state_q == S_NEG) & neg_berr_q);
    assign bus.overlay  = overlay_q;

endmodule
`default_nettype wire

// File: doc/m68k_bus_ctrl.md
# m68k_bus_ctrl

Parametrised 68000 bus controller that replaces the fixed address decoder and DTACK generator in the CPLD. It decodes `addr[23:13]` into up to `NREGIONS` active-low chip selects, each with its own programmable wait-state count or external acknowledge. It also provides the boot overlay of the boot device at address 0 and drives DTACK/BERR as actively-negated, tri-stateable signals. It sits between the CPU bus pins and the memory/peripheral chip selects, clocked by `clk16`, from which the CPU clock is derived.

## Interface
Parameters:
- `NREGIONS`, 4, number of decoded regions, 1..8; lowest index has priority on overlap.
- `REGION_BASE`, `{11'h180,11'h100,11'h080,11'h000}`, packed 11-bit page bases (`addr[23:13]`); region 0 in the LSBs.
- `REGION_MASK`, `{11'h780,11'h7F8,11'h7FE,11'h780}`, packed 11-bit compare masks; region i hits when `(addr & MASK_i) == BASE_i`.
- `REGION_WAIT`, `{4'hF,4'd2,4'd4,4'd0}`, packed 4-bit wait states per region; `4'hF` means wait for `ext_ack[i]`.
- `BOOT_REGION`, 1, region mapped at address 0 while the overlay is active.
- `OVL_PAGES`, 2, overlay size in 8 KB pages, so the default overlay covers 0x000000–0x003FFF.
- `TIMEOUT`, 255, watchdog limit in `clk16` cycles; 8-bit counter.

Ports:
- `clk16` in 1: system clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `as_n`, `uds_n`, `lds_n`, `rw` in 1 each: CPU bus strobes.
- `boot` in 1: bootloader mode. Forces the overlay on for reads and writes and suppresses internal DTACK.
- `addr` in 11: CPU `A23..A13`.
- `ext_ack` in `NREGIONS`: external acknowledge, used only by regions with wait value `4'hF`.
- `cs_n` out `NREGIONS`: one-hot active-low chip selects.
- `dtack_n`, `dtack_oe` out 1 each: DTACK level and its pad output enable.
- `berr_n`, `berr_oe` out 1 each: BERR level and its pad output enable.
- `overlay` out 1: 1 while the boot device is mapped at 0.

## Operation
Decode (combinational, gated by `~as_n`):
- While `overlay` is set, a read with `addr < OVL_PAGES` selects `BOOT_REGION`. When `boot` is high this also applies to writes.
- Otherwise the lowest-index hitting region is selected.
- With no hit, `cs_n` is all ones and the cycle is unmapped.

Overlay:
- `overlay` is set on reset.
- It clears at the first `clk16` edge that sees `~as_n & ~rw & ~boot` with `addr < OVL_PAGES`. That write is decoded to the normal region, with RAM underneath.

State machine, registered on `clk16`: `IDLE`, `WAIT`, `ACK`, `BERR`, `NEG`.
- `IDLE`:
  - `~as_n & ~(uds_n & lds_n)` on a mapped region, not `boot`: load `wcnt = REGION_WAIT[i]` and go to `WAIT`. A value of 0 goes directly to `ACK`.
  - Same condition on an unmapped address: go to `BERR`.
  - With `boot`: stay in `IDLE`; the external programmer drives DTACK.
- `WAIT`:
  - Decrement `wcnt` until it reaches 0, then go to `ACK`.
  - For a `4'hF` region, go to `ACK` on the cycle `ext_ack[i]` is sampled high instead.
- `ACK`: `dtack_n=0`, `dtack_oe=1`. Go to `NEG` when `as_n` is sampled high.
- `BERR`: `berr_n=0`, `berr_oe=1`. Go to `NEG` when `as_n` is sampled high.
- `NEG`: drive the previously asserted signal high with its `oe` held at 1 for exactly one cycle, then go to `IDLE` with `oe=0`.
- `as_n` rising in `WAIT` (aborted cycle): go to `IDLE` immediately; no strobe is driven.

## Timing
- Reset values:
  - `cs_n` all ones.
  - `dtack_n=1`, `dtack_oe=0`, `berr_n=1`, `berr_oe=0`.
  - `overlay=1`, state `IDLE`, `wcnt=0`, watchdog 0.
- Reset mid-cycle returns to `IDLE` on the next edge and releases both `oe` signals.
- `cs_n` follows `as_n` and `addr` combinationally; there is no registered latency.
- DTACK latency from the first edge seeing data strobe low is `REGION_WAIT+1` edges. For wait 0 that is 1 edge; for EEPROM (wait 4) it is 5 edges.
- `ext_ack` is sampled directly. The source must be synchronous to `clk16` and held until `as_n` rises.
- Simultaneous events:
  - `as_n` rising in the same cycle as `wcnt` reaching 0: the abort wins.
  - Overlay-clearing write and decode on the same edge: decode uses the pre-edge `overlay` value, so a write is never routed to `BOOT_REGION` unless `boot` is high.

## Configuration
`M68K_BUS_WATCHDOG_EN`:
- Defined: an 8-bit counter runs in `WAIT`. When it reaches `TIMEOUT`, the state goes to `BERR` instead of `ACK`, which covers a missing `ext_ack`. The counter clears in `IDLE`.
- Undefined: there is no watchdog, and `WAIT` on a `4'hF` region waits indefinitely. Unmapped-address BERR still applies.

## Test plan
- Reset, then read `addr=11'h000`: `cs_n[1]=0`, DTACK low 5 edges after the strobe, `overlay=1`.
- Write to `11'h001` with `boot=0`: `cs_n[0]=0`, `overlay` falls at that edge, DTACK after 1 edge. A following read of `11'h000` selects `cs_n[0]`.
- Read `11'h100` (IO, wait 2): DTACK low after 3 edges. On `as_n` high, `dtack_n=1` with `oe=1` for 1 cycle, then `oe=0`.
- Access `11'h400` (unmapped): `cs_n` all ones, `berr_n=0` after 1 edge, released via `NEG`.
- Access `11'h180` with `ext_ack` raised 7 cycles later: DTACK on the edge after `ext_ack`. With `ext_ack` never raised and the macro defined, `berr_n=0` after 255 cycles.
- `boot=1`, write `11'h000`: `cs_n[1]=0`, `overlay` stays 1, `dtack_oe` stays 0.
